mult_pipe_ctrl: RTL
===================

MULT_PIPE_CTRL -- requirements
Module: mult_pipe_ctrl

Interface
REQ-001 The block SHALL take parameter MULT_STAGES, default 5, the number of multiplier pipeline stages (mult1..multN); legal range 2..8.
REQ-002 The block SHALL take parameter REG_AW, default 5, the register address width.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rsn_i  in  1  reset; synchronous and active-low.
REQ-005 issue_valid_i  in  1  decode presents a multiply for issue.
REQ-006 issue_rd_i  in  REG_AW  destination register of the issuing multiply.
REQ-007 dec_rs1_i, dec_rs2_i  in  REG_AW each  source registers of the instruction in decode.
REQ-008 dec_use_rs1_i, dec_use_rs2_i  in  1 each  qualify dec_rs1_i and dec_rs2_i.
REQ-009 flush_i  in  1  branch/exception squash of the youngest instruction.
REQ-010 alu_wb_valid_i  in  1  ALU requests the register-file write port.
REQ-011 issue_accept_o  out  1  multiply accepted this cycle.
REQ-012 stall_dec_o  out  1  decode must hold because of a hazard.
REQ-013 stage_valid_o  out  MULT_STAGES  per-stage valid bits that drive the stage-latch write enables.
REQ-014 alu_wb_ready_o  out  1  ALU is granted the write port.
REQ-015 wb_valid_o, wb_sel_o  out  1 each  register-file write strobe; wb_sel_o=1 selects the multiplier result.
REQ-016 wb_addr_o  out  REG_AW  register-file write address from the final stage.
REQ-017 inflight_o  out  4  count of valid stages.

Function
REQ-018 The block SHALL keep one valid bit and one rd field per stage, shifting one stage per cycle unconditionally; the multiplier pipeline never stalls.
REQ-019 A register address is in flight when its stage is valid and its rd is not 0.
REQ-020 Hazard SHALL be asserted when any used decode source, or issue_rd_i while issue_valid_i=1, equals the rd of any in-flight stage, the final stage included.
REQ-021 stall_dec_o SHALL equal the hazard condition and SHALL be purely combinational.
REQ-022 issue_accept_o SHALL equal issue_valid_i & !stall_dec_o & !flush_i.
REQ-023 The stage-1 valid bit SHALL load issue_accept_o on each edge, and the stage-1 rd SHALL load issue_rd_i on each edge.
REQ-024 Latency: a multiply accepted in cycle C SHALL show stage_valid_o[k-1]=1 in cycle C+k, and SHALL show wb_valid_o=1, wb_sel_o=1 in cycle C+MULT_STAGES.
REQ-025 flush_i SHALL block issue in the same cycle and SHALL clear the stage-1 valid bit at the next edge; later stages are unaffected.
REQ-026 Write-port arbitration SHALL be fixed-priority, multiplier first: alu_wb_ready_o = !stage_valid_o[MULT_STAGES-1].
REQ-027 wb_valid_o SHALL equal stage_valid_o[MULT_STAGES-1] | alu_wb_valid_i.
REQ-028 wb_sel_o SHALL equal stage_valid_o[MULT_STAGES-1].
REQ-029 When the final stage is valid, wb_addr_o SHALL be the final-stage rd; otherwise wb_addr_o SHALL be 0.
REQ-030 When an ALU request and a multiplier completion coincide, the multiplier SHALL be granted and the ALU SHALL hold its request with no loss.
REQ-031 inflight_o SHALL equal the population count of the stage valid bits and SHALL never exceed MULT_STAGES.
REQ-032 When issue and completion occur in the same cycle, the count SHALL stay unchanged.

Reset
REQ-033 While rsn_i=0 at an edge, all valid bits SHALL clear and all rd fields SHALL become 0.
REQ-034 In the first cycle after reset, stage_valid_o=0, wb_valid_o=alu_wb_valid_i, wb_sel_o=0, wb_addr_o=0, inflight_o=0, stall_dec_o=0, and alu_wb_ready_o=1.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight multiplies without producing a write.

Structure
REQ-036 MULT_STAGES, REG_AW, and the stage-entry struct (valid, rd) SHALL reside in the shared package vi_mult_pkg, used by this block and by the stage latches.
REQ-037 The per-stage rd comparison SHALL be one sub-module, mult_hazard_cmp, instantiated once per compared operand (rs1, rs2, issue rd).

Verification
REQ-038 Reset, then issue rd=3 in cycle 0 -> stage_valid_o walks 00001..10000 in cycles 1..5; wb_valid_o=1, wb_sel_o=1, wb_addr_o=3 in cycle 5.
REQ-039 rd=7 in flight at stage 2, decode rs2=7 with dec_use_rs2_i=1 -> stall_dec_o=1 for exactly 4 cycles; with dec_use_rs2_i=0 -> no stall.
REQ-040 Issue rd=0 -> no hazard on decode rs1=0, and the writeback still occurs with wb_addr_o=0.
REQ-041 alu_wb_valid_i held high while a multiply completes in cycle 5 -> alu_wb_ready_o=0 in cycle 5 only; ALU granted in cycle 6.
REQ-042 issue_valid_i=1 with flush_i=1 -> issue_accept_o=0, stage 1 empty next cycle; a flush one cycle after issue -> that multiply never writes back.
REQ-043 Five back-to-back issues (rd=1..5) -> inflight_o=5 in cycle 5; rsn_i=0 in cycle 3 -> everything empty in cycle 4, and no writeback occurs.

Source files
------------

// File: rtl/vi_mult_pkg.sv
// Shared multiplier pipeline types and defaults.
// Used by the control block and by the stage latches.
package vi_mult_pkg;

  localparam int MULT_STAGES = 5;
  localparam int REG_AW      = 5;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
  } stage_t;

endpackage

// File: rtl/mult_hazard_cmp.sv
// Compares one operand against the rd of every in-flight stage.
// Stages holding rd 0 never count, since x0 is never written.
module mult_hazard_cmp #(
  parameter int N  = 5,
  parameter int AW = 5
) (
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  vld,
  input  logic [N*AW-1:0] rd,
  output logic          hit
);

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && vld[k] &&
          (rd[k*AW +: AW] != '0) &&
          (rd[k*AW +: AW] == addr))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/mult_pipe_ctrl.sv
// Multiplier pipeline control: issue, RAW/WAW hazard stall,
// stage valid tracking and write-port arbitration.
module mult_pipe_ctrl #(
  parameter int MULT_STAGES = vi_mult_pkg::MULT_STAGES,
  parameter int REG_AW      = vi_mult_pkg::REG_AW
) (
  input  logic                   clk_i,
  input  logic                   rsn_i,
  input  logic                   issue_valid_i,
  input  logic [REG_AW-1:0]      issue_rd_i,
  input  logic [REG_AW-1:0]      dec_rs1_i,
  input  logic [REG_AW-1:0]      dec_rs2_i,
  input  logic                   dec_use_rs1_i,
  input  logic                   dec_use_rs2_i,
  input  logic                   flush_i,
  input  logic                   alu_wb_valid_i,
  output logic                   issue_accept_o,
  output logic                   stall_dec_o,
  output logic [MULT_STAGES-1:0] stage_valid_o,
  output logic                   alu_wb_ready_o,
  output logic                   wb_valid_o,
  output logic                   wb_sel_o,
  output logic [REG_AW-1:0]      wb_addr_o,
  output logic [3:0]             inflight_o
);

  import vi_mult_pkg::*;

  stage_t st [MULT_STAGES];

  logic [MULT_STAGES-1:0]        vld;
  logic [MULT_STAGES*REG_AW-1:0] rd_flat;
  logic                          hit_rs1;
  logic                          hit_rs2;
  logic                          hit_rd;
  logic [3:0]                    cnt;

  for (genvar k = 0; k < MULT_STAGES; k++) begin : g_flat
    assign vld[k] = st[k].vld;
    assign rd_flat[k*REG_AW +: REG_AW] = st[k].rd;
  end

  mult_hazard_cmp #(.N(MULT_STAGES), .AW(REG_AW)) u_cmp_rs1 (
    .en   (dec_use_rs1_i),
    .addr (dec_rs1_i),
    .vld  (vld),
    .rd   (rd_flat),
    .hit  (hit_rs1)
  );

  mult_hazard_cmp #(.N(MULT_STAGES), .AW(REG_AW)) u_cmp_rs2 (
    .en   (dec_use_rs2_i),
    .addr (dec_rs2_i),
    .vld  (vld),
    .rd   (rd_flat),
    .hit  (hit_rs2)
  );

  mult_hazard_cmp #(.N(MULT_STAGES), .AW(REG_AW)) u_cmp_rd (
    .en   (issue_valid_i),
    .addr (issue_rd_i),
    .vld  (vld),
    .rd   (rd_flat),
    .hit  (hit_rd)
  );

  assign stall_dec_o    = hit_rs1 | hit_rs2 | hit_rd;
  assign issue_accept_o = issue_valid_i & ~stall_dec_o & ~flush_i;

  // Flush kills the youngest multiply as it leaves stage 1.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      for (int k = 0; k < MULT_STAGES; k++)
        st[k] <= '0;
    end else begin
      st[0].vld <= issue_accept_o;
      st[0].rd  <= issue_rd_i;
      st[1].vld <= st[0].vld & ~flush_i;
      st[1].rd  <= st[0].rd;
      for (int k = 2; k < MULT_STAGES; k++)
        st[k] <= st[k-1];
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < MULT_STAGES; k++)
      cnt = cnt + 4'(vld[k]);
  end

  assign inflight_o     = cnt;
  assign stage_valid_o  = vld;
  assign wb_sel_o       = vld[MULT_STAGES-1];
  assign alu_wb_ready_o = ~vld[MULT_STAGES-1];
  assign wb_valid_o     = vld[MULT_STAGES-1] | alu_wb_valid_i;
  assign wb_addr_o      = vld[MULT_STAGES-1] ?
                          st[MULT_STAGES-1].rd : '0;

endmodule
